// File: rtl/parser_pkg.sv
// Shared parser/deparser definitions: beat layout, tag bit positions and the
// head-insert FSM states.
package parser_pkg;

  localparam int HEAD_WIDTH  = 512;
  localparam int TAG_WIDTH   = 8;
  localparam int SHIFT_WIDTH = 16;
  localparam int INS_MAX     = 8;
  localparam int SLICE_W     = 6;
  localparam int INS_NUM_W   = 4;
  localparam int NUM_SLICES  = HEAD_WIDTH / SHIFT_WIDTH;
  localparam int INS_WIDTH   = INS_MAX * SHIFT_WIDTH;

  localparam int TAG_START = 0;
  localparam int TAG_VALID = 1;
  localparam int TAG_TAIL  = 2;
  localparam int TAG_SHIFT = 3;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [HEAD_WIDTH-1:0] data;
  } head_beat_t;

  typedef enum logic [1:0] {IDLE, BODY, FLUSH} ins_state_e;

  function automatic logic [INS_NUM_W-1:0] clamp_ins_num(input logic [INS_NUM_W-1:0] num);
    return (num > INS_NUM_W'(INS_MAX)) ? INS_NUM_W'(INS_MAX) : num;
  endfunction

endpackage

// File: rtl/head_insert_if.sv
// Beat stream bundle: tagged beat, tail slice count and the upstream stall.
interface head_insert_if;
  import parser_pkg::*;

  head_beat_t           head;
  logic [SLICE_W-1:0]   tail_slices;
  logic                 ready;

  modport master (output head, tail_slices, input ready);
  modport slave  (input head, tail_slices, output ready);
  // Producer side with no stall input, for a sink that never back-pressures.
  modport emit   (output head, tail_slices);

endinterface

// File: rtl/head_insert_slice_realign.sv
// Combinational re-alignment: prepend the top n slices of hi to the beat and
// return the n low slices pushed out, left-aligned, as the next carry.
module slice_realign
  import parser_pkg::*;
(
  input  logic [INS_NUM_W-1:0]  n,
  input  logic [INS_WIDTH-1:0]  hi,
  input  logic [HEAD_WIDTH-1:0] data_in,
  output logic [HEAD_WIDTH-1:0] data_out,
  output logic [INS_WIDTH-1:0]  carry_out
);

  logic [HEAD_WIDTH-1:0] cand_data  [INS_MAX+1];
  logic [INS_WIDTH-1:0]  cand_carry [INS_MAX+1];

  generate
    for (genvar gi = 0; gi <= INS_MAX; gi++) begin : g_shift
      localparam int K = gi * SHIFT_WIDTH;
      if (gi == 0) begin : g_zero
        assign cand_data[gi]  = data_in;
        assign cand_carry[gi] = '0;
      end else if (gi == INS_MAX) begin : g_full
        assign cand_data[gi]  = {hi, data_in[HEAD_WIDTH-1:K]};
        assign cand_carry[gi] = data_in[K-1:0];
      end else begin : g_part
        assign cand_data[gi]  = {hi[INS_WIDTH-1 -: K], data_in[HEAD_WIDTH-1:K]};
        assign cand_carry[gi] = {data_in[K-1:0], {(INS_WIDTH-K){1'b0}}};
      end
    end
  endgenerate

  always_comb begin
    data_out  = cand_data[0];
    carry_out = cand_carry[0];
    for (int i = 1; i <= INS_MAX; i++) begin
      if (n == INS_NUM_W'(i)) begin
        data_out  = cand_data[i];
        carry_out = cand_carry[i];
      end
    end
  end

endmodule

// File: rtl/head_insert.sv
// Deparser head insert: re-prepends n header slices ahead of the payload,
// realigns the following beats and appends a flush beat when the tail overflows.
module head_insert
  import parser_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  head_insert_if.slave          up,
  head_insert_if.emit           dn,
  input  logic [INS_WIDTH-1:0]  i_insData,
  input  logic [INS_NUM_W-1:0]  i_insNum
);

  ins_state_e             state_q, state_d;
  logic [INS_NUM_W-1:0]   n_q, n_d;
  logic [INS_WIDTH-1:0]   carry_q, carry_d;
  logic [SLICE_W-1:0]     flush_t_q, flush_t_d;
  logic                   shift_q, shift_d;
  head_beat_t             head_q, head_d;
  logic [SLICE_W-1:0]     tail_q, tail_d;

  logic                   accept;
  logic                   is_start;
  logic                   is_tail;
  logic [INS_NUM_W-1:0]   n_eff;
  logic [INS_WIDTH-1:0]   hi_sel;
  logic [HEAD_WIDTH-1:0]  realigned;
  logic [INS_WIDTH-1:0]   carry_next;
  logic [SLICE_W:0]       tail_sum;

  // Upstream is stalled only while the flush beat is being emitted.
  assign up.ready = (state_q != FLUSH);
  assign accept   = up.head.tag[TAG_VALID] && up.ready;
  assign is_start = up.head.tag[TAG_START];
  assign is_tail  = up.head.tag[TAG_TAIL];

  always_comb begin
    n_eff = '0;
    if (is_start) begin
      n_eff = clamp_ins_num(i_insNum);
    end else if (state_q == BODY) begin
      n_eff = n_q;
    end
  end

  assign hi_sel   = is_start ? i_insData : carry_q;
  assign tail_sum = {1'b0, up.tail_slices} + (SLICE_W+1)'(n_eff);

  slice_realign u_realign (
    .n         (n_eff),
    .hi        (hi_sel),
    .data_in   (up.head.data),
    .data_out  (realigned),
    .carry_out (carry_next)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    carry_d   = carry_q;
    flush_t_d = flush_t_q;
    shift_d   = shift_q;
    head_d    = '0;
    tail_d    = '0;
    if (state_q == FLUSH) begin
      head_d.data           = {carry_q, {(HEAD_WIDTH-INS_WIDTH){1'b0}}};
      head_d.tag[TAG_VALID] = 1'b1;
      head_d.tag[TAG_TAIL]  = 1'b1;
      head_d.tag[TAG_SHIFT] = shift_q;
      tail_d                = flush_t_q;
      carry_d               = '0;
      state_d               = IDLE;
    end else if (accept) begin
      head_d.tag  = up.head.tag;
      head_d.data = realigned;
      carry_d     = carry_next;
      n_d         = n_eff;
      shift_d     = up.head.tag[TAG_SHIFT];
      state_d     = BODY;
      if (is_tail) begin
        if (tail_sum <= (SLICE_W+1)'(NUM_SLICES)) begin
          tail_d  = tail_sum[SLICE_W-1:0];
          state_d = IDLE;
        end else begin
          // Carried slices spill into an extra beat; this one is no longer the tail.
          head_d.tag[TAG_TAIL] = 1'b0;
          flush_t_d            = SLICE_W'(tail_sum - (SLICE_W+1)'(NUM_SLICES));
          state_d              = FLUSH;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      carry_q   <= '0;
      flush_t_q <= '0;
      shift_q   <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      carry_q   <= carry_d;
      flush_t_q <= flush_t_d;
      shift_q   <= shift_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  assign dn.head        = head_q;
  assign dn.tail_slices = tail_q;

  // A START inside a packet means the previous tail was lost.
  a_lost_tail: assert property (@(posedge i_clk) disable iff (i_rst)
    !(accept && is_start && state_q == BODY));

endmodule

// File: tb/tb_head_insert.sv
// Randomised and directed checks of head_insert against a slice-stream model:
// inserted slices ++ payload slices, re-chunked into 32-slice beats.
module tb_head_insert;
  import parser_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  head_insert_if up_if ();
  head_insert_if dn_if ();
  logic [INS_WIDTH-1:0] ins_data;
  logic [3:0]           ins_num;

  assign dn_if.ready = 1'b1;

  head_insert dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .up        (up_if.slave),
    .dn        (dn_if.emit),
    .i_insData (ins_data),
    .i_insNum  (ins_num)
  );

  typedef struct {
    logic [HEAD_WIDTH-1:0] data;
    logic [7:0]            tag;
    int                    tail;
    int                    cyc;
  } obs_t;

  obs_t got_q[$];
  obs_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   first_stall = 0;
  int   beat_no = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dn_if.head.tag[TAG_VALID] === 1'b1) begin
      obs_t o;
      o.data = dn_if.head.data;
      o.tag  = dn_if.head.tag;
      o.tail = int'(dn_if.tail_slices);
      o.cyc  = cyc;
      got_q.push_back(o);
    end
  end

  task automatic drive_idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      up_if.head        = '0;
      up_if.tail_slices = '0;
    end
  endtask

  task automatic compare_all();
    obs_t e, g;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      $display("beat %0d cyc %0d tag %h tail %0d", beat_no, g.cyc, g.tag, g.tail);
      beat_no++;
      checks++;
      assert (g.data === e.data) else begin
        errors++;
        $error("FAIL data beat %0d observed %h expected %h", beat_no, g.data, e.data);
      end
      checks++;
      assert (g.tag === e.tag) else begin
        errors++;
        $error("FAIL tag beat %0d observed %h expected %h", beat_no, g.tag, e.tag);
      end
      checks++;
      assert (g.tail === e.tail) else begin
        errors++;
        $error("FAIL tail_slices beat %0d observed %0d expected %0d", beat_no, g.tail, e.tail);
      end
      checks++;
      assert (g.cyc === e.cyc) else begin
        errors++;
        $error("FAIL latency beat %0d observed cyc %0d expected cyc %0d", beat_no, g.cyc, e.cyc);
      end
    end
  endtask

  function automatic logic [HEAD_WIDTH-1:0] rand_beat();
    logic [HEAD_WIDTH-1:0] b;
    for (int w = 0; w < HEAD_WIDTH / 32; w++) b[32*w +: 32] = $urandom();
    return b;
  endfunction

  function automatic logic [INS_WIDTH-1:0] rand_ins();
    logic [INS_WIDTH-1:0] v;
    for (int w = 0; w < INS_WIDTH / 32; w++) v[32*w +: 32] = $urandom();
    return v;
  endfunction

  // Drives one packet, then records the expected output beats from the model.
  task automatic send_packet(input int nbeats, input int t, input int insnum,
                             input logic [INS_WIDTH-1:0] ins, input logic shift,
                             input int gap, output logic overflow);
    logic [HEAD_WIDTH-1:0] beats[$];
    logic [15:0]           sl[$];
    int                    acc[$];
    logic [HEAD_WIDTH-1:0] b;
    logic [7:0]            tg;
    int nn, total, nout, c, tries;
    logic accepted;
    obs_t e;

    for (int i = 0; i < nbeats; i++) begin
      b = rand_beat();
      if (i == nbeats - 1)
        for (int s = t; s < NUM_SLICES; s++) b[HEAD_WIDTH-1-16*s -: 16] = '0;
      beats.push_back(b);
    end

    for (int i = 0; i < nbeats; i++) begin
      tries = 0;
      accepted = 1'b0;
      c = 0;
      while (!accepted && tries < 8) begin
        @(negedge clk);
        tg = '0;
        tg[TAG_VALID] = 1'b1;
        tg[TAG_START] = (i == 0);
        tg[TAG_TAIL]  = (i == nbeats - 1);
        tg[TAG_SHIFT] = shift;
        up_if.head.tag    = tg;
        up_if.head.data   = beats[i];
        up_if.tail_slices = SLICE_W'(t);
        ins_data = ins;
        ins_num  = 4'(insnum);
        c = cyc;
        accepted = (up_if.ready === 1'b1);
        @(posedge clk);
        tries++;
      end
      if (i == 0) first_stall = tries - 1;
      checks++;
      assert (accepted) else begin
        errors++;
        $error("FAIL accept_timeout beat %0d observed ready=0 expected accept within 8 cycles", i);
      end
      acc.push_back(c);
    end

    nn = (insnum > INS_MAX) ? INS_MAX : insnum;
    for (int s = 0; s < nn; s++) sl.push_back(ins[INS_WIDTH-1-16*s -: 16]);
    for (int i = 0; i < nbeats; i++) begin
      int cnt = (i == nbeats - 1) ? t : NUM_SLICES;
      for (int s = 0; s < cnt; s++) sl.push_back(beats[i][HEAD_WIDTH-1-16*s -: 16]);
    end
    total = sl.size();
    nout  = (total + NUM_SLICES - 1) / NUM_SLICES;
    for (int o = 0; o < nout; o++) begin
      e.data = '0;
      for (int s = 0; s < NUM_SLICES; s++)
        if (o * NUM_SLICES + s < total) e.data[HEAD_WIDTH-1-16*s -: 16] = sl[o*NUM_SLICES+s];
      e.tag = '0;
      e.tag[TAG_VALID] = 1'b1;
      e.tag[TAG_START] = (o == 0);
      e.tag[TAG_TAIL]  = (o == nout - 1);
      e.tag[TAG_SHIFT] = shift;
      e.tail = (o == nout - 1) ? total - NUM_SLICES * o : 0;
      e.cyc  = (o < nbeats) ? acc[o] + 1 : acc[nbeats-1] + 2;
      exp_q.push_back(e);
    end
    overflow = (nn + t > NUM_SLICES);
    if (gap > 0) drive_idle(gap);
    compare_all();
  endtask

  initial begin
    logic ovf, prev_ovf;
    int prev_gap, nb, tt, nm, gp;
    logic [INS_WIDTH-1:0] ins_v;
    logic [HEAD_WIDTH-1:0] d0;
    obs_t e;

    rst = 1'b1;
    up_if.head = '0;
    up_if.tail_slices = '0;
    ins_data = '0;
    ins_num  = '0;
    repeat (3) @(negedge clk);
    checks++;
    assert (dn_if.head === '0) else begin
      errors++; $error("FAIL reset_head observed %h expected 0", dn_if.head.tag);
    end
    checks++;
    assert (dn_if.tail_slices === '0) else begin
      errors++; $error("FAIL reset_tail observed %0d expected 0", dn_if.tail_slices);
    end
    checks++;
    assert (up_if.ready === 1'b1) else begin
      errors++; $error("FAIL reset_ready observed %b expected 1", up_if.ready);
    end
    rst = 1'b0;
    drive_idle(1);

    // Passthrough, n=0.
    send_packet(3, 5, 0, rand_ins(), 1'b0, 2, ovf);
    checks++;
    assert (first_stall === 0) else begin
      errors++; $error("FAIL n0_stall observed %0d expected 0", first_stall);
    end
    // Two inserted slices, fits in tail.
    send_packet(2, 10, 2, {32'hAAAA_BBBB, 96'h0}, 1'b0, 2, ovf);
    // Overflow needing a flush.
    send_packet(2, 30, 4, rand_ins(), 1'b1, 2, ovf);
    // Single START+TAIL beat, full insert.
    send_packet(1, 32, 8, rand_ins(), 1'b0, 2, ovf);
    // Insert count above the maximum is clamped.
    send_packet(2, 31, 12, rand_ins(), 1'b0, 2, ovf);
    // Back-to-back, first packet overflows: next START stalls one cycle.
    send_packet(3, 28, 6, rand_ins(), 1'b0, 0, ovf);
    send_packet(2, 4, 7, rand_ins(), 1'b1, 0, ovf);
    checks++;
    assert (first_stall === 1) else begin
      errors++; $error("FAIL b2b_flush_stall observed %0d expected 1", first_stall);
    end
    // Back-to-back with no overflow: no stall.
    send_packet(1, 3, 1, rand_ins(), 1'b0, 2, ovf);
    checks++;
    assert (first_stall === 0) else begin
      errors++; $error("FAIL b2b_noflush_stall observed %0d expected 0", first_stall);
    end

    // Reset during beat 1 of a 3-beat packet.
    ins_v = rand_ins();
    d0 = rand_beat();
    @(negedge clk);
    up_if.head.tag = '0;
    up_if.head.tag[TAG_VALID] = 1'b1;
    up_if.head.tag[TAG_START] = 1'b1;
    up_if.head.data = d0;
    up_if.tail_slices = '0;
    ins_data = ins_v;
    ins_num  = 4'd3;
    e.data = {ins_v[INS_WIDTH-1 -: 48], d0[HEAD_WIDTH-1:48]};
    e.tag  = 8'h03;
    e.tail = 0;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    up_if.head.tag[TAG_START] = 1'b0;
    up_if.head.data = rand_beat();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    up_if.head = '0;
    checks++;
    assert (dn_if.head === '0) else begin
      errors++; $error("FAIL reset_mid_head observed tag %h expected 0", dn_if.head.tag);
    end
    checks++;
    assert (up_if.ready === 1'b1) else begin
      errors++; $error("FAIL reset_mid_ready observed %b expected 1", up_if.ready);
    end
    compare_all();
    send_packet(2, 20, 5, rand_ins(), 1'b0, 2, ovf);

    // Random packets; a zero gap after an overflow must cost exactly one stall.
    prev_ovf = 1'b0;
    prev_gap = 2;
    for (int p = 0; p < 30; p++) begin
      nb = $urandom_range(1, 4);
      tt = $urandom_range(1, 32);
      nm = $urandom_range(0, 9);
      gp = (p == 29) ? 2 : $urandom_range(0, 2);
      send_packet(nb, tt, nm, rand_ins(), 1'($urandom_range(0, 1)), gp, ovf);
      checks++;
      assert (first_stall === ((prev_gap == 0 && prev_ovf) ? 1 : 0)) else begin
        errors++;
        $error("FAIL rand_stall pkt %0d observed %0d expected %0d", p, first_stall,
               (prev_gap == 0 && prev_ovf) ? 1 : 0);
      end
      prev_ovf = ovf;
      prev_gap = gp;
    end

    drive_idle(4);
    compare_all();
    checks++;
    assert (exp_q.size() === 0) else begin
      errors++; $error("FAIL missing_beats observed %0d outstanding expected 0", exp_q.size());
    end
    checks++;
    assert (got_q.size() === 0) else begin
      errors++; $error("FAIL extra_beats observed %0d extra expected 0", got_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
